// File: rtl/refcpu_fetch_seq_pkg.sv
// Shared definitions for the refcpu fetch/commit sequencer: states, opcodes, instruction fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package refcpu_fetch_seq_pkg;

    // Sequencer states; the one unused 3-bit encoding is treated as illegal.
    typedef enum logic [2:0] {
        FETCH           = 3'd0,
        FETCH_ADDR_SENT = 3'd1,
        DECODE          = 3'd2,
        BRANCH_EVAL     = 3'd3,
        BRANCH          = 3'd4,
        COMMIT          = 3'd5,
        UNKNOWN         = 3'd6
    } cpu_state_t;

    typedef logic [5:0]  opcode_t;
    typedef logic [4:0]  regid_t;
    typedef logic [15:0] imm16_t;

    // MIPS I-type layout.
    typedef struct packed {
        opcode_t opcode;
        regid_t  rs;
        regid_t  rt;
        imm16_t  imm;
    } instr_t;

    localparam opcode_t OP_BEQ = 6'h04;
    localparam opcode_t OP_BNE = 6'h05;

    // Default for the sequencer's branch-delay-slot behaviour (1 = MIPS delay slot).
    localparam int DELAY_SLOT_DEFAULT = 1;

    function automatic logic is_branch(input opcode_t op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/refcpu_fetch_seq_branch_unit.sv
// Branch unit: BEQ/BNE comparator and pc-relative target adder.
// Latency: purely combinational.
// Backpressure: none; results are sampled by the sequencer when it needs them.
module refcpu_branch_unit
    import refcpu_fetch_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  opcode_t           opcode,
    input  logic [31:0]       rs_val,
    input  logic [31:0]       rt_val,
    input  logic [ADDR_W-1:0] pc,
    input  imm16_t            imm,
    output logic              taken,
    output logic [ADDR_W-1:0] target
);

    // Word offset, sign-extended to the full 32 bits before truncating to ADDR_W.
    logic [31:0] offset;

    // Offset and target wrap modulo 2^ADDR_W.
    always_comb begin
        offset = {{14{imm[15]}}, imm, 2'b00};
        target = pc + ADDR_W'(32'd4) + offset[ADDR_W-1:0];
    end

    // Branch condition per opcode; anything else never takes.
    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:  taken = (rs_val == rt_val);
            OP_BNE:  taken = (rs_val != rt_val);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/refcpu_fetch_seq.sv
// Fetch/decode/branch/commit sequencer for a multi-cycle MIPS-style core.
// Latency: >=3 cycles per instruction (fetch, decode, commit) plus 1-2 for branches.
// Backpressure: holds the fetch request until ireq_addr_ok; waits indefinitely for iresp_data_ok.
module refcpu_fetch_seq
    import refcpu_fetch_seq_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int unsigned RESET_PC   = 0,
    parameter int          DELAY_SLOT = DELAY_SLOT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ireq_valid,
    output logic [ADDR_W-1:0] ireq_addr,
    input  logic              ireq_addr_ok,
    input  logic              iresp_data_ok,
    input  logic [31:0]       iresp_data,
    output regid_t            rs_id,
    output regid_t            rt_id,
    input  logic [31:0]       rs_val,
    input  logic [31:0]       rt_val,
    output logic              commit_valid,
    output logic [ADDR_W-1:0] commit_pc,
    output logic [31:0]       commit_instr,
    output cpu_state_t        state,
    output logic              error
);

    cpu_state_t        state_q;
    cpu_state_t        state_d;
    instr_t            instr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] delayed_pc_q;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] br_target;
    logic              delayed_q;
    logic              br_taken;
    logic              br_taken_q;
    logic              latch_instr;
    logic              bad_state;
    logic              error_q;

    refcpu_branch_unit #(
        .ADDR_W (ADDR_W)
    ) u_branch (
        .opcode (instr_q.opcode),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .pc     (pc_q),
        .imm    (instr_q.imm),
        .taken  (br_taken),
        .target (br_target)
    );

    assign next_pc      = pc_q + ADDR_W'(32'd4);
    assign ireq_addr    = pc_q;
    assign rs_id        = instr_q.rs;
    assign rt_id        = instr_q.rt;
    assign commit_valid = (state_q == COMMIT);
    assign commit_pc    = pc_q;
    assign commit_instr = instr_q;
    assign state        = state_q;
    assign error        = error_q;

    // Next-state logic; a branch sitting in a delay slot decodes as a plain instruction.
    always_comb begin
        state_d     = state_q;
        latch_instr = 1'b0;
        bad_state   = 1'b0;
        case (state_q)
            FETCH: begin
                if (ireq_valid && ireq_addr_ok) begin
                    if (iresp_data_ok) begin
                        state_d     = DECODE;
                        latch_instr = 1'b1;
                    end else begin
                        state_d = FETCH_ADDR_SENT;
                    end
                end
            end
            FETCH_ADDR_SENT: begin
                if (iresp_data_ok) begin
                    state_d     = DECODE;
                    latch_instr = 1'b1;
                end
            end
            DECODE: begin
                if (is_branch(instr_q.opcode) && !delayed_q) begin
                    state_d = BRANCH_EVAL;
                end else begin
                    state_d = COMMIT;
                end
            end
            BRANCH_EVAL: state_d = br_taken ? BRANCH : COMMIT;
            BRANCH:      state_d = COMMIT;
            COMMIT:      state_d = FETCH;
            default: begin
                state_d   = UNKNOWN;
                bad_state = 1'b1;
            end
        endcase
    end

    // State register; the fetch request is registered so it stays low through reset and
    // rises on the first edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            ireq_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            ireq_valid <= (state_d == FETCH);
        end
    end

    // Instruction latch, branch bookkeeping, pc update at commit and the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= ADDR_W'(RESET_PC);
            delayed_q    <= 1'b0;
            delayed_pc_q <= '0;
            instr_q      <= '0;
            br_taken_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            if (latch_instr) begin
                instr_q <= iresp_data;
            end
            if (state_q == BRANCH_EVAL) begin
                br_taken_q <= br_taken;
            end
            if (state_q == BRANCH) begin
                delayed_pc_q <= br_target;
            end
            if (state_q == COMMIT) begin
                br_taken_q <= 1'b0;
                if (delayed_q) begin
                    pc_q      <= delayed_pc_q;
                    delayed_q <= 1'b0;
                end else if (br_taken_q && (DELAY_SLOT != 0)) begin
                    pc_q      <= next_pc;
                    delayed_q <= 1'b1;
                end else if (br_taken_q) begin
                    pc_q <= delayed_pc_q;
                end else begin
                    pc_q <= next_pc;
                end
            end
            if (bad_state) begin
                error_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_refcpu_fetch_seq.sv
module tb_refcpu_fetch_seq;
    import refcpu_fetch_seq_pkg::*;

    logic        clk;
    logic        reset;
    logic        ireq_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    // u0: 32-bit, reset pc 0, delay slot on
    logic        v0, cv0, err0;
    logic [31:0] a0, cpc0, ci0;
    regid_t      rsid0, rtid0;
    cpu_state_t  st0;
    // u1: 32-bit, reset pc 0, delay slot off
    logic        v1, cv1, err1;
    logic [31:0] a1, cpc1, ci1;
    regid_t      rsid1, rtid1;
    cpu_state_t  st1;
    // u2: 16-bit, reset pc 0xFFFC, delay slot on
    logic        v2, cv2, err2;
    logic [15:0] a2, cpc2;
    logic [31:0] ci2;
    regid_t      rsid2, rtid2;
    cpu_state_t  st2;

    int n_assert = 0;
    int n_fail   = 0;

    refcpu_fetch_seq #(.ADDR_W(32), .RESET_PC(0), .DELAY_SLOT(1)) u0 (
        .clk(clk), .reset(reset), .ireq_valid(v0), .ireq_addr(a0),
        .ireq_addr_ok(ireq_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .rs_id(rsid0), .rt_id(rtid0), .rs_val(rs_val), .rt_val(rt_val),
        .commit_valid(cv0), .commit_pc(cpc0), .commit_instr(ci0), .state(st0), .error(err0));

    refcpu_fetch_seq #(.ADDR_W(32), .RESET_PC(0), .DELAY_SLOT(0)) u1 (
        .clk(clk), .reset(reset), .ireq_valid(v1), .ireq_addr(a1),
        .ireq_addr_ok(ireq_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .rs_id(rsid1), .rt_id(rtid1), .rs_val(rs_val), .rt_val(rt_val),
        .commit_valid(cv1), .commit_pc(cpc1), .commit_instr(ci1), .state(st1), .error(err1));

    refcpu_fetch_seq #(.ADDR_W(16), .RESET_PC(32'hFFFC), .DELAY_SLOT(1)) u2 (
        .clk(clk), .reset(reset), .ireq_valid(v2), .ireq_addr(a2),
        .ireq_addr_ok(ireq_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .rs_id(rsid2), .rt_id(rtid2), .rs_val(rs_val), .rt_val(rt_val),
        .commit_valid(cv2), .commit_pc(cpc2), .commit_instr(ci2), .state(st2), .error(err2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One non-branch instruction with same-cycle accept/response; ends back in FETCH.
    task automatic run_nop();
        iresp_data    = 32'h0;
        ireq_addr_ok  = 1'b1;
        iresp_data_ok = 1'b1;
        step();
        ireq_addr_ok  = 1'b0;
        iresp_data_ok = 1'b0;
        step();
        step();
    endtask

    // Accept and respond in the same cycle; ends in DECODE.
    task automatic fetch_now(input logic [31:0] word);
        iresp_data    = word;
        ireq_addr_ok  = 1'b1;
        iresp_data_ok = 1'b1;
        step();
        ireq_addr_ok  = 1'b0;
        iresp_data_ok = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        ireq_addr_ok  = 1'b0;
        iresp_data_ok = 1'b0;
        iresp_data    = 32'h0;
        rs_val        = 32'h0;
        rt_val        = 32'h0;

        // ---- reset state ----
        #1 reset = 1'b1;
        #1;
        chk("rst_state0", 32'(st0), 32'(FETCH));
        chk("rst_valid0", 32'(v0), 32'd0);
        chk("rst_commit0", 32'(cv0), 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_addr0", a0, 32'h0);
        chk("rst_addr2", 32'(a2), 32'h0000_FFFC);
        step();
        chk("rst_hold_valid0", 32'(v0), 32'd0);
        #5 reset = 1'b0;
        step();
        chk("first_valid0", 32'(v0), 32'd1);
        chk("first_addr0", a0, 32'h0);

        // ---- data_ok in FETCH without addr_ok is ignored ----
        iresp_data    = 32'hDEAD_BEEF;
        iresp_data_ok = 1'b1;
        step();
        iresp_data_ok = 1'b0;
        chk("stray_data_state0", 32'(st0), 32'(FETCH));
        chk("stray_data_valid0", 32'(v0), 32'd1);

        // ---- addr_ok, then data_ok three cycles later ----
        iresp_data   = 32'h012A_4020;
        ireq_addr_ok = 1'b1;
        step();
        ireq_addr_ok = 1'b0;
        chk("sent_state0", 32'(st0), 32'(FETCH_ADDR_SENT));
        chk("sent_valid0", 32'(v0), 32'd0);
        step();
        step();
        chk("wait_state0", 32'(st0), 32'(FETCH_ADDR_SENT));
        iresp_data_ok = 1'b1;
        step();
        iresp_data_ok = 1'b0;
        iresp_data    = 32'h0;
        chk("dec_state0", 32'(st0), 32'(DECODE));
        chk("dec_rs0", 32'(rsid0), 32'd9);
        chk("dec_rt0", 32'(rtid0), 32'd10);
        chk("dec_cv0", 32'(cv0), 32'd0);
        step();
        chk("cm_cv0", 32'(cv0), 32'd1);
        chk("cm_pc0", cpc0, 32'h0);
        chk("cm_instr0", ci0, 32'h012A_4020);
        chk("cm_pc2", 32'(cpc2), 32'h0000_FFFC);
        step();
        chk("nxt_state0", 32'(st0), 32'(FETCH));
        chk("nxt_cv0", 32'(cv0), 32'd0);
        chk("nxt_addr0", a0, 32'h4);
        chk("wrap_addr2", 32'(a2), 32'h0);

        // ---- addr_ok and data_ok together ----
        fetch_now(32'h0);
        chk("fast_state0", 32'(st0), 32'(DECODE));
        step();
        chk("fast_cv0", 32'(cv0), 32'd1);
        chk("fast_pc0", cpc0, 32'h4);
        step();
        chk("fast_addr0", a0, 32'h8);

        // ---- BEQ taken with delay slot at 0x10 ----
        run_nop();
        run_nop();
        chk("pre_beq_addr0", a0, 32'h10);
        rs_val = 32'h55;
        rt_val = 32'h55;
        fetch_now(32'h1022_0002);
        chk("beq_rs0", 32'(rsid0), 32'd1);
        chk("beq_rt0", 32'(rtid0), 32'd2);
        step();
        chk("beq_eval0", 32'(st0), 32'(BRANCH_EVAL));
        step();
        chk("beq_br0", 32'(st0), 32'(BRANCH));
        step();
        chk("beq_cm_pc0", cpc0, 32'h10);
        chk("beq_cv0", 32'(cv0), 32'd1);
        step();
        chk("slot_addr0", a0, 32'h14);
        chk("nods_beq_addr1", a1, 32'h1C);
        // the slot holds a BNE that would be taken; it must commit as a plain instruction
        rs_val = 32'h1;
        rt_val = 32'h2;
        fetch_now(32'h1422_0005);
        step();
        chk("slot_cm_state0", 32'(st0), 32'(COMMIT));
        chk("slot_cm_pc0", cpc0, 32'h14);
        step();
        chk("target_addr0", a0, 32'h1C);

        // ---- reset while a fetch is outstanding ----
        ireq_addr_ok = 1'b1;
        step();
        ireq_addr_ok = 1'b0;
        chk("pre_rst_state0", 32'(st0), 32'(FETCH_ADDR_SENT));
        #2 reset = 1'b1;
        #1;
        chk("async_state0", 32'(st0), 32'(FETCH));
        chk("async_valid0", 32'(v0), 32'd0);
        chk("async_addr0", a0, 32'h0);
        chk("async_addr2", 32'(a2), 32'h0000_FFFC);
        #3 reset = 1'b0;
        iresp_data    = 32'h012A_4020;
        iresp_data_ok = 1'b1;
        step();
        chk("late_state0", 32'(st0), 32'(FETCH));
        chk("late_addr2", 32'(a2), 32'h0000_FFFC);
        chk("late_cv0", 32'(cv0), 32'd0);
        step();
        iresp_data_ok = 1'b0;
        chk("late2_state0", 32'(st0), 32'(FETCH));
        chk("late2_cv0", 32'(cv0), 32'd0);
        chk("late2_addr0", a0, 32'h0);

        // ---- BNE without delay slot at 0x10, taken then not taken ----
        for (int i = 0; i < 4; i++) run_nop();
        chk("pre_bne_addr1", a1, 32'h10);
        chk("wrap2_addr2", 32'(a2), 32'h000C);
        rs_val = 32'h1;
        rt_val = 32'h2;
        fetch_now(32'h1464_FFFC);
        step();
        chk("bne_eval1", 32'(st1), 32'(BRANCH_EVAL));
        step();
        chk("bne_br1", 32'(st1), 32'(BRANCH));
        step();
        chk("bne_cm_pc1", cpc1, 32'h10);
        step();
        chk("bne_taken_addr1", a1, 32'h04);
        for (int i = 0; i < 3; i++) run_nop();
        chk("pre_bne2_addr1", a1, 32'h10);
        rs_val = 32'h7;
        rt_val = 32'h7;
        fetch_now(32'h1464_FFFC);
        step();
        chk("bne2_eval1", 32'(st1), 32'(BRANCH_EVAL));
        step();
        chk("bne2_cm_state1", 32'(st1), 32'(COMMIT));
        chk("bne2_cm_pc1", cpc1, 32'h10);
        step();
        chk("bne_nt_addr1", a1, 32'h14);

        chk("end_err0", 32'(err0), 32'd0);
        chk("end_err1", 32'(err1), 32'd0);
        chk("end_err2", 32'(err2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/refcpu_fetch_seq.md
REFCPU_FETCH_SEQ -- requirements
Module: refcpu_fetch_seq

Interface
REQ-001 SHALL take parameter ADDR_W, default 32: PC and instruction-address width; legal range 16..32.
REQ-002 SHALL take parameter RESET_PC, default 0: PC value loaded on reset; truncated to ADDR_W.
REQ-003 SHALL take parameter DELAY_SLOT, default 1: 1 gives MIPS branch delay slot; 0 redirects immediately after a taken branch.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port ireq_valid, output, 1 bit: instruction fetch request.
REQ-007 SHALL have port ireq_addr, output, ADDR_W bits: fetch address, equal to pc.
REQ-008 SHALL have port ireq_addr_ok, input, 1 bit: request accepted this cycle.
REQ-009 SHALL have port iresp_data_ok, input, 1 bit: instruction word valid this cycle.
REQ-010 SHALL have port iresp_data, input, 32 bits: instruction word.
REQ-011 SHALL have ports rs_id and rt_id, output, 5 bits each: instr[25:21] and instr[20:16] of the latched instruction.
REQ-012 SHALL have ports rs_val and rt_val, input, 32 bits each: combinational register-file read data.
REQ-013 SHALL have port commit_valid, output, 1 bit: one-cycle retire pulse.
REQ-014 SHALL have ports commit_pc, output, ADDR_W bits, and commit_instr, output, 32 bits: retired PC and instruction.
REQ-015 SHALL have port state, output, cpu_state_t: current state.
REQ-016 SHALL have port error, output, 1 bit: sticky illegal-state flag.

Function
REQ-017 SHALL implement the states FETCH, FETCH_ADDR_SENT, DECODE, BRANCH_EVAL, BRANCH, COMMIT and UNKNOWN.
REQ-018 SHALL, in FETCH, drive ireq_valid=1 with ireq_addr=pc; on ireq_addr_ok move to FETCH_ADDR_SENT, or to DECODE with instr latched if iresp_data_ok is also 1 in the same cycle.
REQ-019 SHALL, in FETCH_ADDR_SENT, hold ireq_valid=0 and wait any number of cycles for iresp_data_ok, then latch iresp_data into instr and move to DECODE.
REQ-020 SHALL ignore iresp_data_ok in every state other than FETCH_ADDR_SENT and the FETCH cycle that sees ireq_addr_ok.
REQ-021 SHALL, in DECODE, move to BRANCH_EVAL when opcode is OP_BEQ or OP_BNE and the instruction is not in a delay slot; otherwise it SHALL move to COMMIT.
REQ-022 SHALL, in BRANCH_EVAL, compute taken as (rs_val==rt_val) for BEQ and (rs_val!=rt_val) for BNE; taken moves to BRANCH, not taken moves to COMMIT.
REQ-023 SHALL, in BRANCH, latch delayed_pc = pc+4+(sign-extended imm<<2), computed modulo 2^ADDR_W with wrap-around, then move to COMMIT.
REQ-024 SHALL, in COMMIT, pulse commit_valid for one cycle with commit_pc=pc and commit_instr=instr, then move to FETCH.
REQ-025 SHALL update pc at COMMIT by the first matching rule:
- delayed=1: pc<=delayed_pc, delayed<=0.
- taken branch, DELAY_SLOT=1: pc<=pc+4, delayed<=1.
- taken branch, DELAY_SLOT=0: pc<=delayed_pc.
- otherwise: pc<=pc+4.
REQ-026 SHALL treat a branch in a delay slot as a non-branch, with no second redirect.
REQ-027 SHALL compute next_pc = pc+4 combinationally, wrapping at 2^ADDR_W.
REQ-028 SHALL, on any state encoding outside REQ-017, go to UNKNOWN, set error, and stay there until reset.

Reset
REQ-029 SHALL, on reset asserted, immediately and asynchronously set: state=FETCH, pc=RESET_PC, delayed=0, delayed_pc=0, instr=0, error=0, ireq_valid=0, commit_valid=0.
REQ-030 SHALL start the first fetch in the first clock edge after reset deasserts; a response to a fetch in flight before reset SHALL NOT be latched.

Structure
REQ-031 SHALL take cpu_state_t, opcode_t, regid_t and the instruction field typedefs from the shared defs package; a new DELAY_SLOT default constant SHALL also go in that package.
REQ-032 SHALL place the branch comparator and target adder in one sub-module, refcpu_branch_unit.

Verification
REQ-033 Bench SHALL cover: reset, addr_ok at cycle 1, data_ok 3 cycles later -> ireq_addr=0, DECODE entered after data_ok, commit_pc=0, next ireq_addr=4.
REQ-034 Bench SHALL cover: addr_ok and data_ok in the same cycle -> FETCH_ADDR_SENT skipped, commit 3 cycles later.
REQ-035 Bench SHALL cover: DELAY_SLOT=1, BEQ at pc 0x10 with imm=2, rs_val=rt_val -> commits at 0x10, 0x14, then fetch at 0x1C.
REQ-036 Bench SHALL cover: DELAY_SLOT=0, BNE at pc 0x10 with imm=-4, rs_val!=rt_val -> next fetch at 0x04; with equal values -> next fetch at 0x14.
REQ-037 Bench SHALL cover: ADDR_W=16, pc=0xFFFC with a non-branch -> next fetch at 0x0000.
REQ-038 Bench SHALL cover: reset asserted in FETCH_ADDR_SENT, then data_ok after release -> response ignored, ireq_addr=RESET_PC, no commit_valid.
